// File: rtl/l2_cache_writeback_drain.sv
// l2_cache_writeback_drain
// Queues evicted dirty L2 lines (address + 512-bit data) and serializes the
// head line to system memory as BEATS beats over a valid/ready port.
// Optional feature macro: L2_WB_FORWARD_EN enables the forward lookup
// (fwd_hit/fwd_data) into queued lines. Without it, fwd_hit/fwd_data are tied 0.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no beat offered; launches a burst next edge if a line is queued
// BURST | head line on the bus, beat_idx selects the beat being offered
module l2_cache_writeback_drain #(
  parameter int FIFO_DEPTH = 4,
  parameter int BEAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_enq_valid,
  input  logic [25:0]           wb_enq_address,
  input  logic [511:0]          wb_enq_data,
  output logic                  wb_full,
  output logic                  wb_empty,
  output logic                  smi_valid,
  input  logic                  smi_ready,
  output logic [31:0]           smi_address,
  output logic [BEAT_WIDTH-1:0] smi_data,
  output logic                  smi_last,
  input  logic [25:0]           fwd_address,
  output logic                  fwd_hit,
  output logic [511:0]          fwd_data
);

  localparam int BEATS = 512 / BEAT_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BI_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BI_W-1:0]  LAST_BEAT  = BI_W'(BEATS - 1);
  localparam logic [31:0]      BEAT_BYTES = 32'(BEAT_WIDTH / 8);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t state, state_nxt;

  logic [25:0]  fifo_addr [FIFO_DEPTH];
  logic [511:0] fifo_data [FIFO_DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [BI_W-1:0]  beat_idx, beat_idx_nxt;
  logic             push, pop;
  logic [BEATS-1:0][BEAT_WIDTH-1:0] head_beats;

  // Full is a pure function of count: a pop on the same edge does not free a slot.
  assign wb_full  = (count == CNT_FULL);
  assign wb_empty = (count == '0) && (state == IDLE);
  assign push     = wb_enq_valid && !wb_full;

  // Next-state, beat advance and pop decision.
  always_comb begin
    state_nxt    = state;
    beat_idx_nxt = beat_idx;
    smi_valid    = 1'b0;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        beat_idx_nxt = '0;
        if (count != '0) state_nxt = BURST;
      end
      BURST: begin
        smi_valid = 1'b1;
        if (smi_ready) begin
          if (beat_idx == LAST_BEAT) begin
            pop          = 1'b1;
            beat_idx_nxt = '0;
            state_nxt    = IDLE;
          end else begin
            beat_idx_nxt = beat_idx + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat payload: MSB-first slice of the head line, zero when nothing is offered.
  always_comb begin
    head_beats  = fifo_data[head];
    smi_address = '0;
    smi_data    = '0;
    smi_last    = 1'b0;
    if (state == BURST) begin
      smi_address = {fifo_addr[head], 6'b0} + (32'(beat_idx) * BEAT_BYTES);
      smi_data    = head_beats[LAST_BEAT - beat_idx];
      smi_last    = (beat_idx == LAST_BEAT);
    end
  end

  // State, beat counter, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      beat_idx <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      beat_idx <= beat_idx_nxt;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Line storage; contents need no reset since occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[tail] <= wb_enq_address;
      fifo_data[tail] <= wb_enq_data;
    end
  end

`ifndef SYNTHESIS
  // Flag lines lost because upstream pushed into a full queue.
  always_ff @(posedge clk) begin
    if (!reset && wb_enq_valid && wb_full)
      $display("%m: error: enqueue of line %h dropped, writeback queue full", wb_enq_address);
  end
`endif

`ifdef L2_WB_FORWARD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Scan oldest to youngest so the youngest matching line wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = head;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      fwd_idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (fifo_addr[fwd_idx] == fwd_address)) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_data[fwd_idx];
      end
    end
  end
`else
  logic unused_fwd;

  assign unused_fwd = ^fwd_address;
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule
